gpio_mux_safe_switch: RTL and testbench

//   Parametrised GPIO pin mux routing one of NUM_PROJECTS projects' io_out/io_oeb bits to each pad.
//   Per-pin selects are staged in shadow registers and applied together by a commit strobe.
//   A changed pin is parked (oeb=1, out=0) for SWITCH_GAP cycles before reconnecting (break-before-make).

---
 rtl/gpio_mux_safe_switch.sv | 119 +++++++++++
 tb/tb_gpio_mux_safe_switch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mux_safe_switch.sv
// Per-pad project mux with shadowed selects, a commit strobe and a break-before-make park gap.
// Each pad is driven from the registered output of the mux. A pad whose select changes is parked while it switches.
//
// state   | meaning
// ST_IDLE | pad driven from active select (parked if select >= NUM_PROJECTS)
// ST_GAP  | pad parked, counting down before active takes the latched target
module gpio_mux_safe_switch #(
  parameter int NUM_PINS     = 38,
  parameter int NUM_PROJECTS = 13,
  parameter int SEL_W        = 4,
  parameter int SWITCH_GAP   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PROJECTS*NUM_PINS-1:0] io_oeb,
  input  logic [NUM_PROJECTS*NUM_PINS-1:0] io_out,
  input  logic                             cfg_we,
  input  logic [$clog2(NUM_PINS)-1:0]      cfg_pin,
  input  logic [SEL_W-1:0]                 cfg_sel,
  input  logic                             cfg_commit,
  output logic [NUM_PINS-1:0]              muxxed_io_oeb,
  output logic [NUM_PINS-1:0]              muxxed_io_out,
  output logic                             busy,
  output logic                             cfg_err
);

  localparam int CNT_W = (SWITCH_GAP < 2) ? 1 : $clog2(SWITCH_GAP);
  localparam int IDX_W = $clog2(NUM_PROJECTS*NUM_PINS);
  localparam logic [SEL_W-1:0] PARK = '1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SWITCH_GAP > 0) ? SWITCH_GAP - 1 : 0);

  typedef enum logic {ST_IDLE, ST_GAP} pin_state_t;

  pin_state_t        state  [NUM_PINS];
  logic [SEL_W-1:0]  shadow [NUM_PINS];
  logic [SEL_W-1:0]  active [NUM_PINS];
  logic [SEL_W-1:0]  target [NUM_PINS];
  logic [CNT_W-1:0]  cnt    [NUM_PINS];

  logic [NUM_PINS-1:0] in_gap;
  logic [NUM_PINS-1:0] oeb_d;
  logic [NUM_PINS-1:0] out_d;
  logic [IDX_W-1:0]    idx;
  logic                pin_bad;
  logic                commit_ok;

  always_comb begin
    in_gap = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      in_gap[i] = (state[i] == ST_GAP);
    end
  end

  assign busy      = |in_gap;
  assign pin_bad   = int'(cfg_pin) >= NUM_PINS;
  assign commit_ok = cfg_commit && !busy;

  // A pin in its gap, or pointing at a non-existent project, is parked.
  always_comb begin
    oeb_d = '1;
    out_d = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (state[i] == ST_IDLE && int'(active[i]) < NUM_PROJECTS) begin
        idx      = IDX_W'(int'(active[i]) * NUM_PINS + i);
        oeb_d[i] = io_oeb[idx];
        out_d[i] = io_out[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PINS; i++) begin
        state[i]  <= ST_IDLE;
        shadow[i] <= PARK;
        active[i] <= PARK;
        target[i] <= PARK;
        cnt[i]    <= '0;
      end
      muxxed_io_oeb <= '1;
      muxxed_io_out <= '0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= (cfg_we && pin_bad) || (cfg_commit && busy);
      if (cfg_we && !pin_bad) begin
        shadow[cfg_pin] <= cfg_sel;
      end
      for (int i = 0; i < NUM_PINS; i++) begin
        case (state[i])
          ST_IDLE: begin
            // target is latched here so shadow writes during the gap cannot retarget it
            if (commit_ok && shadow[i] != active[i]) begin
              if (SWITCH_GAP == 0) begin
                active[i] <= shadow[i];
              end else begin
                state[i]  <= ST_GAP;
                cnt[i]    <= CNT_LOAD;
                target[i] <= shadow[i];
              end
            end
          end
          ST_GAP: begin
            if (cnt[i] == '0) begin
              active[i] <= target[i];
              state[i]  <= ST_IDLE;
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
      muxxed_io_oeb <= oeb_d;
      muxxed_io_out <= out_d;
    end
  end

endmodule

// File: tb/tb_gpio_mux_safe_switch.sv
// Scoreboard bench for gpio_mux_safe_switch: stimulus queues expected pad state per cycle,
// a negedge monitor pops and compares.
module tb_gpio_mux_safe_switch;

  localparam int NP  = 38;
  localparam int NPR = 13;
  localparam int NB  = NP * NPR;

  typedef logic [3:0] sel_arr_t [NP];

  typedef struct {
    int          cyc;
    string       name;
    logic [37:0] eo;
    logic [37:0] eu;
    logic        eb;
    logic        ee;
    bit          dio;
  } exp_t;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic [NB-1:0] io_oeb;
  logic [NB-1:0] io_out;
  logic          cfg_we;
  logic [5:0]    cfg_pin;
  logic [3:0]    cfg_sel;
  logic          cfg_commit;
  logic [NP-1:0] muxxed_io_oeb;
  logic [NP-1:0] muxxed_io_out;
  logic          busy;
  logic          cfg_err;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  sel_arr_t m_shadow;
  sel_arr_t m_active;

  gpio_mux_safe_switch dut (
    .clk(tb_clk), .rst(rst), .io_oeb(io_oeb), .io_out(io_out),
    .cfg_we(cfg_we), .cfg_pin(cfg_pin), .cfg_sel(cfg_sel), .cfg_commit(cfg_commit),
    .muxxed_io_oeb(muxxed_io_oeb), .muxxed_io_out(muxxed_io_out),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  // Monitor: compare every entry whose cycle has come.
  initial begin
    exp_t e;
    forever begin
      @(negedge tb_clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (e.cyc != cyc) begin
          n_bad++;
          $display("FAIL %s: checked at cyc %0d, required cyc %0d", e.name, cyc, e.cyc);
        end else if ((e.dio && (muxxed_io_oeb !== e.eo || muxxed_io_out !== e.eu)) ||
                     busy !== e.eb || cfg_err !== e.ee) begin
          n_bad++;
          $display("FAIL %s cyc=%0d oeb got %h want %h, out got %h want %h, busy got %b want %b, err got %b want %b",
                   e.name, cyc, muxxed_io_oeb, e.eo, muxxed_io_out, e.eu, busy, e.eb, cfg_err, e.ee);
        end
      end
    end
  end

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic expect_at(input int c, input string nm, input logic [37:0] eo, input logic [37:0] eu,
                           input logic eb, input logic ee, input bit dio);
    exp_t e;
    int   pos;
    e.cyc = c; e.name = nm; e.eo = eo; e.eu = eu; e.eb = eb; e.ee = ee; e.dio = dio;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > c) pos--;
    sb.insert(pos, e);
  endtask

  function automatic void calc(input sel_arr_t s, output logic [37:0] o, output logic [37:0] u);
    o = '1;
    u = '0;
    for (int i = 0; i < NP; i++) begin
      if (s[i] < 4'd13) begin
        o[i] = io_oeb[int'(s[i]) * NP + i];
        u[i] = io_out[int'(s[i]) * NP + i];
      end
    end
  endfunction

  task automatic rand_io();
    for (int b = 0; b < NB; b++) begin
      io_oeb[b] = 1'($urandom_range(0, 1));
      io_out[b] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wr(input int pin, input int sel);
    cfg_we  = 1'b1;
    cfg_pin = 6'(pin);
    cfg_sel = 4'(sel);
    if (pin >= NP) begin
      expect_at(cyc + 1, "bad_pin_err", '1, '0, 1'b0, 1'b1, 1'b0);
      expect_at(cyc + 2, "bad_pin_err_clr", '1, '0, 1'b0, 1'b0, 1'b0);
    end else begin
      m_shadow[pin] = 4'(sel);
    end
    step();
    cfg_we = 1'b0;
  endtask

  // Commit with busy low; expected outputs derived from the bench model (gap of 2).
  task automatic commit_check(input string nm);
    logic [37:0] pre_o, pre_u, post_o, post_u, chg;
    int n;
    calc(m_active, pre_o, pre_u);
    calc(m_shadow, post_o, post_u);
    chg = '0;
    for (int i = 0; i < NP; i++) chg[i] = (m_shadow[i] != m_active[i]);
    cfg_commit = 1'b1;
    n = cyc + 1;
    if (chg != '0) begin
      expect_at(n,     {nm, "_n"},   pre_o,       pre_u,        1'b1, 1'b0, 1'b1);
      expect_at(n + 1, {nm, "_gap1"}, pre_o | chg, pre_u & ~chg, 1'b1, 1'b0, 1'b1);
      expect_at(n + 2, {nm, "_gap2"}, pre_o | chg, pre_u & ~chg, 1'b0, 1'b0, 1'b1);
      expect_at(n + 3, {nm, "_new"},  post_o,      post_u,       1'b0, 1'b0, 1'b1);
    end else begin
      for (int k = 0; k < 4; k++) expect_at(n + k, {nm, "_same"}, pre_o, pre_u, 1'b0, 1'b0, 1'b1);
    end
    step();
    cfg_commit = 1'b0;
    step(); step(); step();
    m_active = m_shadow;
  endtask

  initial begin
    logic [37:0] pre_o, pre_u, post_o, post_u;
    sel_arr_t    tmp;
    int          n;

    for (int i = 0; i < NP; i++) begin
      m_shadow[i] = 4'hF;
      m_active[i] = 4'hF;
    end
    rst = 1'b1; cfg_we = 1'b0; cfg_pin = '0; cfg_sel = '0; cfg_commit = 1'b0;
    rand_io();

    // reset held two cycles with random inputs
    expect_at(1, "reset1", 38'h3F_FFFF_FFFF, 38'h0, 1'b0, 1'b0, 1'b1);
    expect_at(2, "reset2", 38'h3F_FFFF_FFFF, 38'h0, 1'b0, 1'b0, 1'b1);
    step(); step();
    rst = 1'b0;
    expect_at(cyc + 1, "post_reset", 38'h3F_FFFF_FFFF, 38'h0, 1'b0, 1'b0, 1'b1);
    step();

    // pin 5 -> project 3 with hand-computed pads
    io_out = '0;
    io_oeb = '1;
    io_out[3*NP+5] = 1'b1;
    io_oeb[3*NP+5] = 1'b0;
    wr(5, 3);
    n = cyc + 1;
    expect_at(n + 1, "p5_park1", 38'h3F_FFFF_FFFF, 38'h0, 1'b1, 1'b0, 1'b1);
    expect_at(n + 2, "p5_park2", 38'h3F_FFFF_FFFF, 38'h0, 1'b0, 1'b0, 1'b1);
    expect_at(n + 3, "p5_live",  38'h3F_FFFF_FFDF, 38'h20, 1'b0, 1'b0, 1'b1);
    commit_check("p5");

    // out-of-range pin: error pulse, no shadow change, following commit is a no-op
    wr(40, 0);
    commit_check("bad_pin_noop");

    // unchanged re-commit while the selected project toggles
    for (int j = 0; j < 6; j++) begin
      for (int b = 0; b < NB; b++) io_out[b] = 1'($urandom_range(0, 1));
      cfg_commit = 1'b1;
      calc(m_active, pre_o, pre_u);
      expect_at(cyc + 1, "follow", pre_o, pre_u, 1'b0, 1'b0, 1'b1);
      step();
    end
    cfg_commit = 1'b0;

    // commit while busy is rejected; the pin 7 write still lands
    rand_io();
    wr(6, 4);
    calc(m_active, pre_o, pre_u);
    tmp = m_active;
    tmp[6] = 4'd4;
    calc(tmp, post_o, post_u);
    cfg_commit = 1'b1;
    n = cyc + 1;
    expect_at(n,     "bc_start",  pre_o | 38'h40, pre_u & ~38'h40, 1'b1, 1'b0, 1'b1);
    expect_at(n + 1, "bc_reject", pre_o | 38'h40, pre_u & ~38'h40, 1'b1, 1'b1, 1'b1);
    expect_at(n + 2, "bc_gap",    pre_o | 38'h40, pre_u & ~38'h40, 1'b0, 1'b0, 1'b1);
    expect_at(n + 3, "bc_new",    post_o, post_u, 1'b0, 1'b0, 1'b1);
    expect_at(n + 4, "bc_norest", post_o, post_u, 1'b0, 1'b0, 1'b1);
    step();
    cfg_we = 1'b1; cfg_pin = 6'd7; cfg_sel = 4'd2;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    step(); step(); step();
    m_active = tmp;
    m_shadow[7] = 4'd2;
    commit_check("late_commit");

    // random selects including park codes
    for (int it = 0; it < 60; it++) begin
      rand_io();
      for (int p = 0; p < NP; p++) wr(p, $urandom_range(0, 15));
      commit_check("random");
    end

    // reset in the middle of a gap
    rand_io();
    wr(0, (m_active[0] == 4'd1) ? 2 : 1);
    cfg_commit = 1'b1;
    n = cyc + 1;
    expect_at(n, "mid_gap_busy", '1, '0, 1'b1, 1'b0, 1'b0);
    step();
    cfg_commit = 1'b0;
    rst = 1'b1;
    expect_at(n + 1, "mid_gap_rst", 38'h3F_FFFF_FFFF, 38'h0, 1'b0, 1'b0, 1'b1);
    expect_at(n + 2, "after_rst",   38'h3F_FFFF_FFFF, 38'h0, 1'b0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_shadow[i] = 4'hF;
      m_active[i] = 4'hF;
    end
    step();
    commit_check("rst_noop");

    for (int t = 0; t < 20 && sb.size() > 0; t++) step();
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
